// File: rtl/ssd1306_spi_receiver_pkg.sv
// Shared types and constants for the SSD1306 SPI receiver: bit count, FSM states,
// the FIFO entry layout and a small counter helper.
package ssd1306_pkg;

  localparam int SPI_BITS  = 8;
  localparam int BIT_CNT_W = $clog2(SPI_BITS);
  localparam int CNT_W     = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic                dc;
    logic [SPI_BITS-1:0] data_byte;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Clear has priority over an increment landing in the same cycle; wraps at 0xFFFF.
  function automatic logic [CNT_W-1:0] count_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             clr,
                                                  input logic             inc);
    if (clr) return '0;
    return cnt + {{(CNT_W-1){1'b0}}, inc};
  endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_if.sv
// Push/pop bundle between the SPI byte assembler (master) and the entry FIFO (slave).
interface ssd1306_spi_receiver_if #(
  parameter int WIDTH = 9
);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             full;
  logic             empty;

  modport master (
    output push,
    output push_data,
    output pop,
    input  pop_data,
    input  full,
    input  empty
  );

  modport slave (
    input  push,
    input  push_data,
    input  pop,
    output pop_data,
    output full,
    output empty
  );

endinterface

// File: rtl/ssd1306_spi_receiver_sync_fifo.sv
// Single-clock FIFO with a combinational head; a push into a full FIFO only
// succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                    clk_in,
  input  logic                    resetn_in,
  ssd1306_spi_receiver_if.slave   fifo_bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign fifo_bus.full     = (count_q == (AW+1)'(DEPTH));
  assign fifo_bus.empty    = (count_q == '0);
  assign fifo_bus.pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = fifo_bus.pop & ~fifo_bus.empty;
    do_push  = fifo_bus.push & (~fifo_bus.full | do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = fifo_bus.push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SPI mode-0 receiver for an SSD1306-style command/data stream: oversampled
// SPI pins, byte assembly, entry FIFO with ready/valid output and status counters.
module ssd1306_spi_receiver
  import ssd1306_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                resetn_in,
  input  logic                spi_csn_in,
  input  logic                spi_clk_in,
  input  logic                spi_mosi_in,
  input  logic                spi_dc_in,
  output logic [SPI_BITS-1:0] byte_out,
  output logic                dc_out,
  output logic                byte_valid_out,
  input  logic                byte_ready_in,
  input  logic                clear_in,
  output logic                overflow_out,
  output logic                frame_err_out,
  output logic [CNT_W-1:0]    cmd_count_out,
  output logic [CNT_W-1:0]    data_count_out
);

  // Pin vector order {dc, mosi, sclk, csn}; reset levels match an idle bus.
  localparam logic [3:0] PIN_IDLE = 4'b0001;

  logic [3:0]           meta_q, meta_d;
  logic [3:0]           sync_q, sync_d;
  logic                 sclk_dly_q, sclk_dly_d;
  logic                 csn_s, sclk_s, mosi_s, dc_s, sclk_rise;

  state_e               state_q, state_d;
  logic [SPI_BITS-1:0]  shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_err_q, frame_err_d;
  logic [CNT_W-1:0]     cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]     data_cnt_q, data_cnt_d;

  logic                 byte_done;
  logic                 frame_err_set;
  logic                 pop;
  entry_t               push_entry;
  entry_t               head;

  ssd1306_spi_receiver_if #(.WIDTH(ENTRY_W)) fifo_bus ();

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_in    (clk_in),
    .resetn_in (resetn_in),
    .fifo_bus  (fifo_bus)
  );

  always_comb begin
    meta_d     = {spi_dc_in, spi_mosi_in, spi_clk_in, spi_csn_in};
    sync_d     = meta_q;
    sclk_dly_d = sync_q[1];
  end

  assign csn_s     = sync_q[0];
  assign sclk_s    = sync_q[1];
  assign mosi_s    = sync_q[2];
  assign dc_s      = sync_q[3];
  assign sclk_rise = sclk_s & ~sclk_dly_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_done     = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (!csn_s) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (csn_s) begin
          // Deselect in the middle of a byte throws the partial byte away.
          state_d       = ST_IDLE;
          frame_err_set = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          shift_d       = '0;
        end else if (sclk_rise) begin
          shift_d   = {shift_q[SPI_BITS-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          byte_done = (bit_cnt_q == BIT_CNT_W'(SPI_BITS - 1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign push_entry         = '{dc: dc_s, data_byte: shift_d};
  assign pop                = byte_valid_out & byte_ready_in;
  assign fifo_bus.push      = byte_done;
  assign fifo_bus.push_data = push_entry;
  assign fifo_bus.pop       = pop;
  assign head               = entry_t'(fifo_bus.pop_data);

  always_comb begin
    overflow_d  = clear_in ? 1'b0 : (overflow_q | (byte_done & fifo_bus.full & ~pop));
    frame_err_d = clear_in ? 1'b0 : (frame_err_q | frame_err_set);
    cmd_cnt_d   = count_step(cmd_cnt_q, clear_in, byte_done & ~dc_s);
    data_cnt_d  = count_step(data_cnt_q, clear_in, byte_done & dc_s);
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      meta_q      <= PIN_IDLE;
      sync_q      <= PIN_IDLE;
      sclk_dly_q  <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_cnt_q   <= '0;
      data_cnt_q  <= '0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sclk_dly_q  <= sclk_dly_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      cmd_cnt_q   <= cmd_cnt_d;
      data_cnt_q  <= data_cnt_d;
    end
  end

  // Head is forced to zero while empty so stale storage never shows on the outputs.
  assign byte_valid_out = ~fifo_bus.empty;
  assign byte_out       = byte_valid_out ? head.data_byte : '0;
  assign dc_out         = byte_valid_out ? head.dc : 1'b0;
  assign overflow_out   = overflow_q;
  assign frame_err_out  = frame_err_q;
  assign cmd_count_out  = cmd_cnt_q;
  assign data_count_out = data_cnt_q;

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Directed bench for ssd1306_spi_receiver with a queue scoreboard of expected
// {dc, byte} entries, drained through the ready/valid port.
module tb_ssd1306_spi_receiver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        csn = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        dc = 1'b0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  byte_out;
  logic        dc_out;
  logic        valid;
  logic        ovf;
  logic        ferr;
  logic [15:0] cmd_cnt;
  logic [15:0] data_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];

  always #5 clk = ~clk;

  ssd1306_spi_receiver #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_in         (clk),
    .resetn_in      (resetn),
    .spi_csn_in     (csn),
    .spi_clk_in     (sclk),
    .spi_mosi_in    (mosi),
    .spi_dc_in      (dc),
    .byte_out       (byte_out),
    .dc_out         (dc_out),
    .byte_valid_out (valid),
    .byte_ready_in  (ready),
    .clear_in       (clr),
    .overflow_out   (ovf),
    .frame_err_out  (ferr),
    .cmd_count_out  (cmd_cnt),
    .data_count_out (data_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI bit; the rising edge lands on a negedge so the push cycle is predictable.
  task automatic spi_bit(input logic b, input logic d, input bit pop_here);
    logic [8:0] head;
    @(negedge clk);
    mosi = b;
    dc   = d;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    if (pop_here) begin
      repeat (2) @(negedge clk);
      chk("pop_valid", 32'(valid), 32'd1);
      head = exp_q.pop_front();
      chk("pop_entry", 32'({dc_out, byte_out}), 32'(head));
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic d, input bit pop_last);
    csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) spi_bit(b[7-i], d, pop_last && (i == nbits - 1));
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d, input bit pop_last);
    send_bits(b, 8, d, pop_last);
    if (exp_q.size() < DEPTH) exp_q.push_back({d, b});
  endtask

  task automatic drain(input string tag);
    int         guard = 0;
    logic [8:0] e;
    while (exp_q.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (valid) begin
        e = exp_q.pop_front();
        chk({tag, "_entry"}, 32'({dc_out, byte_out}), 32'(e));
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_empty"}, 32'(valid), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_dc", 32'(dc_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_cmd", 32'(cmd_cnt), 32'd0);
    chk("rst_data", 32'(data_cnt), 32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Command then data byte
    send_byte(8'hAE, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    chk("basic_cmd", 32'(cmd_cnt), 32'd1);
    chk("basic_data", 32'(data_cnt), 32'd1);
    drain("basic");

    // Overflow: six data bytes with the consumer stalled
    do_clear();
    for (int i = 0; i < 6; i++) send_byte(8'h50 + 8'(i), 1'b1, 1'b0);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_data", 32'(data_cnt), 32'd6);
    chk("ovf_cmd", 32'(cmd_cnt), 32'd0);
    chk("ovf_hold0", 32'({dc_out, byte_out}), 32'(exp_q[0]));
    repeat (5) @(negedge clk);
    chk("ovf_hold1", 32'({dc_out, byte_out}), 32'(exp_q[0]));
    drain("ovf");

    // Frame error on a 5-bit partial byte, then a clean byte
    do_clear();
    chk("clr_ovf", 32'(ovf), 32'd0);
    send_bits(8'hF0, 5, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    chk("ferr_flag", 32'(ferr), 32'd1);
    chk("ferr_cmd", 32'(cmd_cnt), 32'd1);
    drain("ferr");
    do_clear();
    chk("clr_ferr", 32'(ferr), 32'd0);
    chk("clr_cmd", 32'(cmd_cnt), 32'd0);

    // Full FIFO with a pop landing on the same cycle as the next push
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b0);
    chk("full_ovf0", 32'(ovf), 32'd0);
    send_byte(8'h14, 1'b1, 1'b1);
    chk("full_ovf1", 32'(ovf), 32'd0);
    chk("full_data", 32'(data_cnt), 32'd5);
    drain("full");

    // Reset in the middle of a byte
    do_clear();
    csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    csn    = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_ferr", 32'(ferr), 32'd0);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    send_byte(8'h81, 1'b1, 1'b0);
    chk("mid_rst_ferr2", 32'(ferr), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_data", 32'(data_cnt), 32'd1);
    drain("mid_rst");

    // Clock activity with chip select high is ignored
    do_clear();
    mosi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("idle_valid", 32'(valid), 32'd0);
    chk("idle_cmd", 32'(cmd_cnt), 32'd0);
    chk("idle_data", 32'(data_cnt), 32'd0);
    chk("idle_ferr", 32'(ferr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_receiver.md
SSD1306_SPI_RECEIVER -- requirements
Module: ssd1306_spi_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, received-byte FIFO entries; power of two, minimum 2.
REQ-002 clk_in  input  1  system clock; all logic on its rising edge; SHALL run at least 4x the SPI clock rate.
REQ-003 resetn_in  input  1  reset; asynchronous assert, active-low.
REQ-004 spi_csn_in  input  1  SPI chip select, active-low, asynchronous to clk_in.
REQ-005 spi_clk_in  input  1  SPI clock (mode 0), asynchronous to clk_in.
REQ-006 spi_mosi_in  input  1  serial data, MSB first.
REQ-007 spi_dc_in  input  1  SSD1306 D/C line: 0 command, 1 data.
REQ-008 byte_out  output  8  received byte at FIFO head.
REQ-009 dc_out  output  1  D/C value captured with byte_out.
REQ-010 byte_valid_out  output  1  FIFO not empty.
REQ-011 byte_ready_in  input  1  consumer accepts the head entry.
REQ-012 clear_in  input  1  synchronous clear of sticky flags and counters.
REQ-013 overflow_out  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-014 frame_err_out  output  1  sticky: chip select deasserted mid-byte.
REQ-015 cmd_count_out  output  16  completed command bytes received.
REQ-016 data_count_out  output  16  completed data bytes received.

Function
REQ-017 spi_csn_in, spi_clk_in, spi_mosi_in and spi_dc_in SHALL each pass a 2-flop synchronizer; a third register on the synchronized clock provides rising-edge detection.
REQ-018 FSM states: IDLE (synchronized csn high) and SHIFT (csn low); IDLE->SHIFT on csn low; SHIFT->IDLE on csn high.
REQ-019 In SHIFT, each detected SPI clock rising edge SHALL shift synchronized mosi into the LSB of an 8-bit shift register and increment a 3-bit bit counter.
REQ-020 On the edge completing bit 8, the byte and the synchronized dc sampled on that same edge SHALL be pushed to the FIFO, and the bit counter SHALL wrap to 0.
REQ-021 Pushed entry SHALL appear on byte_out/dc_out with byte_valid_out high on the clk_in cycle after the edge-detect cycle.
REQ-022 Handshake: entry popped when byte_valid_out and byte_ready_in are both high on a rising edge; byte_out/dc_out SHALL hold stable while byte_valid_out is high and byte_ready_in is low.
REQ-023 Push when full without a simultaneous pop: byte dropped, FIFO unchanged, overflow_out set.
REQ-024 Push and pop in the same cycle when full: both performed, no overflow.
REQ-025 Push and pop in the same cycle when empty: not possible, because a push is visible only on the next cycle; pop SHALL be ignored when byte_valid_out is low.
REQ-026 csn rising while bit counter is nonzero: partial byte discarded, bit counter cleared, frame_err_out set; no FIFO push.
REQ-027 Every completed byte, including dropped ones, SHALL increment cmd_count_out (dc=0) or data_count_out (dc=1); counters wrap 0xFFFF->0x0000.
REQ-028 clear_in SHALL zero overflow_out, frame_err_out and both counters; FIFO contents unaffected; when a flag-set or count event occurs in the same cycle, clear wins.
REQ-029 SPI clock edges while csn is high SHALL be ignored.

Reset
REQ-030 Reset assertion SHALL immediately force: FSM IDLE, shift register and bit counter 0, FIFO empty, byte_valid_out 0, byte_out 0x00, dc_out 0, flags 0, counters 0.
REQ-031 Synchronizer flops SHALL reset to idle bus levels (csn 1, clk 0, mosi 0, dc 0), so reset release causes no false edge.
REQ-032 Reset mid-byte SHALL discard the partial byte without setting frame_err_out.

Structure
REQ-033 Package ssd1306_pkg SHALL hold SPI_BITS=8, the FSM state enum, and the FIFO entry struct {dc, byte}.
REQ-034 The FIFO SHALL be a sub-module sync_fifo parameterized by depth and entry width, with push/pop/full/empty ports.

Verification
REQ-035 Send 0xAE with dc=0, then 0xA5 with dc=1 -> two entries (0,0xAE) then (1,0xA5); cmd_count_out=1, data_count_out=1.
REQ-036 Hold byte_ready_in low and send 6 bytes with FIFO_DEPTH=4 -> first 4 retained in order, overflow_out=1, data_count_out=6.
REQ-037 Send 5 bits then raise csn, then send 0x3C -> frame_err_out=1, single entry 0x3C.
REQ-038 FIFO full with byte_ready_in high exactly on the cycle a new byte completes -> no overflow, occupancy stays 4.
REQ-039 Assert resetn_in low mid-byte, release, then send 0x81 -> only 0x81 received, flags 0.
REQ-040 Toggle spi_clk_in 16 times with csn high -> no entries, counters 0.
